// File: rtl/fir_coe_reload_ctrl.sv
// Buffers one symmetric FIR coefficient set and replays it into the FIR reload/config AXI-Stream channels.
// Optional macro COE_REVERSE_EN: replay from the centre tap down to buf[0] instead of 0 upward.
module fir_coe_reload_ctrl #(
  parameter int COE_NUM      = 51,
  parameter int COE_WDTH     = 29,
  parameter int COE_NUM_HALF = (COE_NUM + 1) / 2,
  parameter int RELOAD_WDTH  = 32
) (
  input  logic                          cfg_clk,
  input  logic                          cfg_rst_n,
  input  logic                          fir_en,
  input  logic                          coe_vld,
  input  logic                          coe_sop,
  input  logic signed [COE_WDTH-1:0]    coe_din,
  output logic                          reload_tvalid,
  input  logic                          reload_tready,
  output logic                          reload_tlast,
  output logic signed [RELOAD_WDTH-1:0] reload_tdata,
  output logic                          config_tvalid,
  input  logic                          config_tready,
  output logic [7:0]                    config_tdata,
  output logic                          reload_busy,
  output logic                          reload_done,
  output logic                          reload_err
);

  localparam int IDX_W = (COE_NUM_HALF > 1) ? $clog2(COE_NUM_HALF) : 1;
  localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(COE_NUM_HALF - 1);
`ifdef COE_REVERSE_EN
  localparam logic [IDX_W-1:0] RD_FIRST = LAST_WR;
  localparam logic [IDX_W-1:0] RD_LAST  = '0;
`else
  localparam logic [IDX_W-1:0] RD_FIRST = '0;
  localparam logic [IDX_W-1:0] RD_LAST  = LAST_WR;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_LOAD,
    ST_CONFIG,
    ST_DONE
  } state_t;

  state_t                      state;
  logic [IDX_W-1:0]            wr_idx;
  logic [IDX_W-1:0]            rd_idx;
  logic signed [COE_WDTH-1:0]  coe_mem [COE_NUM_HALF];
  logic                        wr_en;
  logic [IDX_W-1:0]            wr_addr;

  function automatic logic signed [RELOAD_WDTH-1:0] sign_ext(input logic signed [COE_WDTH-1:0] c);
    return RELOAD_WDTH'(c);
  endfunction

  function automatic logic [IDX_W-1:0] rd_next(input logic [IDX_W-1:0] idx);
`ifdef COE_REVERSE_EN
    return idx - 1'b1;
`else
    return idx + 1'b1;
`endif
  endfunction

  // Buffer write side: only IDLE (start of set) and COLLECT may touch the array,
  // so the replayed set is frozen for the whole of LOAD.
  always_comb begin
    wr_en   = fir_en && coe_vld &&
              (((state == ST_IDLE) && coe_sop) || (state == ST_COLLECT));
    wr_addr = coe_sop ? '0 : wr_idx;
  end

  always_ff @(posedge cfg_clk) begin
    if (wr_en) coe_mem[wr_addr] <= coe_din;
  end

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      state         <= ST_IDLE;
      wr_idx        <= '0;
      rd_idx        <= '0;
      reload_tvalid <= 1'b0;
      reload_tlast  <= 1'b0;
      config_tvalid <= 1'b0;
      reload_done   <= 1'b0;
      reload_err    <= 1'b0;
    end else if (!fir_en) begin
      state         <= ST_IDLE;
      wr_idx        <= '0;
      rd_idx        <= '0;
      reload_tvalid <= 1'b0;
      reload_tlast  <= 1'b0;
      config_tvalid <= 1'b0;
      reload_done   <= 1'b0;
      reload_err    <= 1'b0;
    end else begin
      reload_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coe_vld && coe_sop) begin
            wr_idx <= IDX_W'(1);
            state  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (coe_vld) begin
            if (coe_sop) begin
              wr_idx     <= IDX_W'(1);
              reload_err <= 1'b1;
            end else if (wr_idx == LAST_WR) begin
              wr_idx        <= '0;
              rd_idx        <= RD_FIRST;
              reload_tvalid <= 1'b1;
              reload_tlast  <= (RD_FIRST == RD_LAST);
              state         <= ST_LOAD;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (coe_vld) reload_err <= 1'b1;
          if (reload_tvalid && reload_tready) begin
            if (reload_tlast) begin
              reload_tvalid <= 1'b0;
              reload_tlast  <= 1'b0;
              rd_idx        <= '0;
              config_tvalid <= 1'b1;
              state         <= ST_CONFIG;
            end else begin
              rd_idx       <= rd_next(rd_idx);
              reload_tlast <= (rd_next(rd_idx) == RD_LAST);
            end
          end
        end
        ST_CONFIG: begin
          if (coe_vld) reload_err <= 1'b1;
          if (config_tready) begin
            config_tvalid <= 1'b0;
            reload_done   <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (coe_vld) reload_err <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // tdata is forced to zero while idle so the unreset buffer never leaks out.
  assign reload_tdata = reload_tvalid ? sign_ext(coe_mem[rd_idx]) : '0;
  assign config_tdata = 8'h00;
  assign reload_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_fir_coe_reload_ctrl.sv
// Self-checking bench for fir_coe_reload_ctrl: random coefficient sets against a queue-based replay model.
module tb_fir_coe_reload_ctrl;

  localparam int COE_NUM  = 51;
  localparam int COE_WDTH = 29;
  localparam int N        = (COE_NUM + 1) / 2;
  localparam int RW       = 32;
`ifdef COE_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic                cfg_clk = 1'b0;
  logic                cfg_rst_n = 1'b0;
  logic                fir_en = 1'b0;
  logic                coe_vld = 1'b0;
  logic                coe_sop = 1'b0;
  logic [COE_WDTH-1:0] coe_din = '0;
  logic                reload_tvalid;
  logic                reload_tready = 1'b0;
  logic                reload_tlast;
  logic [RW-1:0]       reload_tdata;
  logic                config_tvalid;
  logic                config_tready = 1'b0;
  logic [7:0]          config_tdata;
  logic                reload_busy;
  logic                reload_done;
  logic                reload_err;

  int checks = 0;
  int failures = 0;
  logic [RW:0]         beats[$];
  logic [COE_WDTH-1:0] set_q[$];
  int cfg_hs, cfg_stall, done_cnt;

  always #5 cfg_clk = ~cfg_clk;

  fir_coe_reload_ctrl dut (
    .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .fir_en(fir_en),
    .coe_vld(coe_vld), .coe_sop(coe_sop), .coe_din(coe_din),
    .reload_tvalid(reload_tvalid), .reload_tready(reload_tready),
    .reload_tlast(reload_tlast), .reload_tdata(reload_tdata),
    .config_tvalid(config_tvalid), .config_tready(config_tready),
    .config_tdata(config_tdata), .reload_busy(reload_busy),
    .reload_done(reload_done), .reload_err(reload_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two's-complement value of a coefficient word, re-encoded at reload width.
  function automatic logic [RW-1:0] sx(input logic [COE_WDTH-1:0] w);
    longint v;
    longint half;
    half = longint'(1) << (COE_WDTH - 1);
    v = longint'(w);
    if (v >= half) v = v - 2 * half;
    return RW'(v);
  endfunction

  task automatic step();
    logic hold;
    logic [RW:0] held;
    hold = fir_en && reload_tvalid && !reload_tready;
    held = {reload_tlast, reload_tdata};
    if (fir_en && reload_tvalid && reload_tready) beats.push_back({reload_tlast, reload_tdata});
    if (fir_en && config_tvalid && config_tready) cfg_hs++;
    if (fir_en && config_tvalid && !config_tready) cfg_stall++;
    @(posedge cfg_clk);
    #1;
    if (reload_done) done_cnt++;
    if (hold) chk("stall_hold", {30'd0, reload_tvalid, reload_tlast, reload_tdata}, {30'd0, 1'b1, held});
  endtask

  task automatic clear_mon();
    beats.delete();
    cfg_hs = 0;
    cfg_stall = 0;
    done_cnt = 0;
  endtask

  task automatic rand_set();
    set_q.delete();
    repeat (N) set_q.push_back(COE_WDTH'($urandom));
  endtask

  task automatic send_set(input int hdrs);
    repeat (hdrs) begin
      coe_vld = 1'b1; coe_sop = 1'b0; coe_din = COE_WDTH'($urandom);
      step();
    end
    for (int i = 0; i < N; i++) begin
      coe_vld = 1'b1; coe_sop = (i == 0); coe_din = set_q[i];
      step();
    end
    coe_vld = 1'b0; coe_sop = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1010.., 2: random ready
  task automatic drain(input int mode, input int cfg_hold, input bit stray, input int stop_beats);
    int cyc;
    int cfg_seen;
    cyc = 0;
    cfg_seen = 0;
    while (done_cnt == 0 && cyc < 600 && !(stop_beats >= 0 && beats.size() >= stop_beats)) begin
      case (mode)
        0: reload_tready = 1'b1;
        1: reload_tready = (cyc % 2 == 0);
        default: reload_tready = 1'($urandom_range(0, 1));
      endcase
      config_tready = (cfg_seen >= cfg_hold);
      if (config_tvalid) cfg_seen++;
      if (stray && reload_tvalid && (cyc % 3 == 1)) begin
        coe_vld = 1'b1; coe_sop = 1'($urandom_range(0, 1)); coe_din = COE_WDTH'($urandom);
      end else begin
        coe_vld = 1'b0; coe_sop = 1'b0;
      end
      step();
      cyc++;
    end
    coe_vld = 1'b0; coe_sop = 1'b0;
    chk("drain_bound", {63'd0, cyc < 600}, 64'd1);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 64'(beats.size()), 64'(N));
    for (int i = 0; i < beats.size() && i < N; i++) begin
      int k;
      k = REV ? (N - 1 - i) : i;
      chk($sformatf("%s_data%0d", tag, i), 64'(beats[i][RW-1:0]), 64'(sx(set_q[k])));
      chk($sformatf("%s_last%0d", tag, i), 64'(beats[i][RW]), 64'(i == N - 1));
    end
  endtask

  task automatic finish_set(input string tag, input int exp_stall);
    chk({tag, "_cfg_hs"}, 64'(cfg_hs), 64'd1);
    chk({tag, "_cfg_stall"}, 64'(cfg_stall), 64'(exp_stall));
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    step();
    chk({tag, "_done_width"}, 64'(done_cnt), 64'd1);
    chk({tag, "_idle"}, {62'd0, reload_busy, reload_done}, 64'd0);
  endtask

  task automatic pulse_en();
    fir_en = 1'b0;
    step();
    fir_en = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge cfg_clk);
    #1;
    chk("rst_tvalid", 64'(reload_tvalid), 64'd0);
    chk("rst_tlast", 64'(reload_tlast), 64'd0);
    chk("rst_tdata", 64'(reload_tdata), 64'd0);
    chk("rst_cfg", {55'd0, config_tvalid, config_tdata}, 64'd0);
    chk("rst_flags", {61'd0, reload_busy, reload_done, reload_err}, 64'd0);
    cfg_rst_n = 1'b1;
    fir_en = 1'b1;
    step();
    step();

    // Set 0..N-1, ready always high
    clear_mon();
    set_q.delete();
    for (int i = 0; i < N; i++) set_q.push_back(COE_WDTH'(i));
    for (int i = 0; i < N; i++) begin
      coe_vld = 1'b1; coe_sop = (i == 0); coe_din = set_q[i];
      if (i == N - 1) chk("t1_pre_valid", {62'd0, reload_tvalid, reload_busy}, 64'd1);
      step();
    end
    coe_vld = 1'b0; coe_sop = 1'b0;
    chk("t1_valid_after_last_write", 64'(reload_tvalid), 64'd1);
    drain(0, 0, 1'b0, -1);
    check_beats("t1");
    chk("t1_err", 64'(reload_err), 64'd0);
    finish_set("t1", 0);

    // Negative word and toggling ready
    clear_mon();
    rand_set();
    set_q[0] = 29'h1000_0000;
    send_set(0);
    drain(1, 0, 1'b0, -1);
    check_beats("t2");
    if (beats.size() == N)
      chk("t2_neg_sext", 64'(beats[REV ? N - 1 : 0][RW-1:0]), 64'hF000_0000);
    finish_set("t2", 0);

    // Header words, then restart mid-set
    pulse_en();
    clear_mon();
    rand_set();
    send_set(2);
    chk("t3_hdr_err", 64'(reload_err), 64'd0);
    drain(2, 0, 1'b0, -1);
    check_beats("t3a");
    finish_set("t3a", 0);
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      coe_vld = 1'b1; coe_sop = (i == 0); coe_din = COE_WDTH'($urandom);
      step();
    end
    rand_set();
    send_set(0);
    chk("t3_restart_err", 64'(reload_err), 64'd1);
    drain(0, 0, 1'b0, -1);
    check_beats("t3b");
    finish_set("t3b", 0);

    // Abort on reload beat 12, then a fresh set
    clear_mon();
    rand_set();
    send_set(0);
    chk("t4_err_before", 64'(reload_err), 64'd1);
    drain(0, 0, 1'b0, 12);
    chk("t4_beats_before_abort", 64'(beats.size()), 64'd12);
    fir_en = 1'b0;
    step();
    chk("t4_abort_valids", {61'd0, reload_tvalid, reload_tlast, config_tvalid}, 64'd0);
    chk("t4_abort_flags", {61'd0, reload_busy, reload_done, reload_err}, 64'd0);
    step();
    fir_en = 1'b1;
    step();
    clear_mon();
    rand_set();
    send_set(0);
    drain(2, 0, 1'b0, -1);
    check_beats("t4");
    finish_set("t4", 0);

    // Stray words during replay, config ready held off 5 cycles
    pulse_en();
    clear_mon();
    rand_set();
    send_set(0);
    drain(2, 5, 1'b1, -1);
    check_beats("t5");
    chk("t5_err", 64'(reload_err), 64'd1);
    finish_set("t5", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
